// File: rtl/disp_value_reg_pkg.sv
// disp_value_reg_pkg: shared register offsets, bit indices, FSM states and display limit
package disp_value_reg_pkg;
  localparam logic [3:0] OFF_VALUE = 4'h0;
  localparam logic [3:0] OFF_CTRL = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;
  localparam int CTRL_HOLD_EN = 0;
  localparam int CTRL_FREEZE = 1;
  localparam int STAT_PENDING = 0;
  localparam int STAT_OVF = 1;
  localparam logic [15:0] DISP_LIMIT = 16'd9999;
  typedef enum logic {ST_IDLE, ST_RESP} state_t;
endpackage

// File: rtl/disp_holdoff_timer.sv
// disp_holdoff_timer: hold-off countdown; loads HOLD_CYCLES-1 on commit, flags zero (ports: clk, rst, commit in; zero out)
module disp_holdoff_timer #(
  parameter logic [31:0] HOLD_CYCLES = 32'd1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic commit,
  output logic zero
);
  logic [31:0] hold_cnt;
  assign zero = hold_cnt == 32'd0;
  always_ff @(posedge clk or posedge rst)
    if (rst) hold_cnt <= '0;
    else hold_cnt <= commit ? HOLD_CYCLES - 32'd1 : zero ? hold_cnt : hold_cnt - 32'd1;
endmodule

// File: rtl/disp_value_reg.sv
// disp_value_reg: bus-mapped display value register with saturation, hold-off and freeze (ports: bus valid/ready slave, data/overflow to translator)
module disp_value_reg
  import disp_value_reg_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h1000_0000,
  parameter logic [31:0] HOLD_CYCLES = 32'd1_000_000,
  parameter logic [15:0] MAX_VAL = DISP_LIMIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_valid,
  input  logic        bus_we,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic [3:0]  bus_wstrb,
  output logic        bus_ready,
  output logic [31:0] bus_rdata,
  output logic [15:0] data,
  output logic        overflow
);
  state_t state;
  logic [15:0] pend_val, nv;
  logic [3:0] off;
  logic [31:0] rd;
  logic pending, ovf, hold_en, freeze, zero, commit, acc, wr_val, wr_ctrl, wr_stat, sat, ovf_clr;
  logic unused_bits;
  assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:16], bus_wstrb[3:2]};
  assign overflow = ovf;
  always_comb begin
    off = {bus_addr[3:2], 2'b00};
    acc = state == ST_IDLE && bus_valid && bus_addr[31:4] == ADDR_BASE[31:4];
    wr_val = acc && bus_we && off == OFF_VALUE;
    wr_ctrl = acc && bus_we && off == OFF_CTRL && bus_wstrb[0];
    wr_stat = acc && bus_we && off == OFF_STATUS;
    nv = {bus_wstrb[1] ? bus_wdata[15:8] : pend_val[15:8], bus_wstrb[0] ? bus_wdata[7:0] : pend_val[7:0]};
    sat = nv > MAX_VAL;
    ovf_clr = wr_stat && bus_wstrb[0] && bus_wdata[STAT_OVF];
    commit = pending && !freeze && (!hold_en || zero);
    rd = off == OFF_VALUE  ? {16'b0, data} :
         off == OFF_CTRL   ? {30'b0, freeze, hold_en} :
         off == OFF_STATUS ? {30'b0, ovf, pending} : 32'b0;
  end
  disp_holdoff_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
    .clk(clk),
    .rst(rst),
    .commit(commit),
    .zero(zero)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      bus_ready <= 1'b0;
      bus_rdata <= '0;
      data <= '0;
      pend_val <= '0;
      pending <= 1'b0;
      ovf <= 1'b0;
      hold_en <= 1'b0;
      freeze <= 1'b0;
    end else begin
      state <= acc ? ST_RESP : ST_IDLE;
      bus_ready <= acc;
      bus_rdata <= acc && !bus_we ? rd : '0;
      if (wr_val) pend_val <= sat ? MAX_VAL : nv;
      if (commit) data <= pend_val;
      // a write landing on a commit edge keeps the new value pending
      pending <= wr_val || (pending && !commit);
      ovf <= (wr_val && sat) || (ovf && !ovf_clr);
      if (wr_ctrl) begin
        hold_en <= bus_wdata[CTRL_HOLD_EN];
        freeze <= bus_wdata[CTRL_FREEZE];
      end
    end
endmodule

// File: tb/tb_disp_value_reg.sv
// tb_disp_value_reg: directed and randomized checks of disp_value_reg against a timestamp-based model
module tb_disp_value_reg;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int HOLD = 10;
  logic clk = 0, rst = 1, bus_valid = 0, bus_we = 0;
  logic [31:0] bus_addr = 0, bus_wdata = 0, bus_rdata;
  logic [3:0] bus_wstrb = 0;
  logic bus_ready, overflow;
  logic [15:0] data;
  int checks = 0, errors = 0;
  longint cyc = 0, m_last = -1000000, t0;
  logic [15:0] m_data, m_pend;
  logic m_pending, m_ovf, m_hold, m_freeze, m_resp;
  logic [31:0] m_rdata, r;
  int seen;

  disp_value_reg #(.ADDR_BASE(BASE), .HOLD_CYCLES(32'(HOLD)), .MAX_VAL(16'd9999)) dut (
    .clk(clk), .rst(rst), .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
    .data(data), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_data = 0; m_pend = 0; m_pending = 0; m_ovf = 0; m_hold = 0; m_freeze = 0;
    m_resp = 0; m_rdata = 0; m_last = -1000000;
  endtask

  task automatic tick();
    logic acc, cm;
    logic [3:0] off;
    logic [15:0] nv;
    off = {bus_addr[3:2], 2'b00};
    acc = !rst && !m_resp && bus_valid && bus_addr[31:4] == BASE[31:4];
    cm = !rst && m_pending && !m_freeze && (!m_hold || cyc - m_last >= HOLD);
    @(posedge clk);
    if (m_resp) begin
      m_resp = 0; m_rdata = 0;
    end else if (acc) begin
      m_resp = 1;
      m_rdata = bus_we ? 32'h0 : off == 4'h0 ? {16'h0, m_data} : off == 4'h4 ? {30'h0, m_freeze, m_hold} :
                off == 4'h8 ? {30'h0, m_ovf, m_pending} : 32'h0;
    end
    if (cm) begin
      m_data = m_pend; m_pending = 0; m_last = cyc;
    end
    if (acc && bus_we) begin
      if (off == 4'h0) begin
        nv = {bus_wstrb[1] ? bus_wdata[15:8] : m_pend[15:8], bus_wstrb[0] ? bus_wdata[7:0] : m_pend[7:0]};
        if (nv > 16'd9999) begin m_pend = 16'd9999; m_ovf = 1; end
        else m_pend = nv;
        m_pending = 1;
      end else if (off == 4'h4 && bus_wstrb[0]) begin
        m_hold = bus_wdata[0]; m_freeze = bus_wdata[1];
      end else if (off == 4'h8 && bus_wstrb[0] && bus_wdata[1]) m_ovf = 0;
    end
    cyc++;
    #1;
    chk("data", 32'(data), 32'(m_data));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("bus_ready", 32'(bus_ready), 32'(m_resp));
    chk("bus_rdata", bus_rdata, m_rdata);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus_valid = 1; bus_we = 1; bus_addr = a; bus_wdata = d; bus_wstrb = s;
    tick();
    tick();
    bus_valid = 0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] q);
    bus_valid = 1; bus_we = 0; bus_addr = a;
    tick();
    q = bus_rdata;
    tick();
    bus_valid = 0;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data", 32'(data), 0);
    chk("reset_ready", 32'(bus_ready), 0);
    chk("reset_rdata", bus_rdata, 0);
    chk("reset_ovf", 32'(overflow), 0);
    rst = 0;
    tick();
    // basic write, hold-off disabled
    wr(BASE, 32'd1234, 4'hF);
    chk("t1_data", 32'(data), 32'd1234);
    rd(BASE + 8, r);
    chk("t1_status", r, 32'h0);
    // saturation and W1C
    wr(BASE, 32'd12000, 4'hF);
    chk("sat_data", 32'(data), 32'd9999);
    chk("sat_ovf", 32'(overflow), 1);
    wr(BASE + 8, 32'h2, 4'hF);
    chk("w1c_ovf", 32'(overflow), 0);
    chk("w1c_data", 32'(data), 32'd9999);
    // hold-off spacing
    wr(BASE + 4, 32'h1, 4'h1);
    wr(BASE, 32'd5, 4'hF);
    for (int i = 0; i < 40 && data !== 16'd5; i++) tick();
    t0 = cyc;
    wr(BASE, 32'd6, 4'hF);
    for (int i = 0; i < 40 && data !== 16'd6; i++) tick();
    chk("hold_gap", 32'(cyc - t0), 32'(HOLD));
    // last write wins inside the hold window
    seen = 0;
    wr(BASE, 32'd7, 4'hF);
    wr(BASE, 32'd8, 4'hF);
    wr(BASE, 32'd9, 4'hF);
    for (int i = 0; i < 40 && data !== 16'd9; i++) begin
      tick();
      if (data == 16'd7 || data == 16'd8) seen++;
    end
    chk("no_interm", 32'(seen), 0);
    chk("last_wins", 32'(data), 32'd9);
    // freeze
    wr(BASE + 4, 32'h2, 4'h1);
    wr(BASE, 32'd42, 4'hF);
    repeat (5) tick();
    chk("frz_data", 32'(data), 32'd9);
    rd(BASE + 8, r);
    chk("frz_status", r, 32'h1);
    wr(BASE + 4, 32'h0, 4'h1);
    chk("unfrz_data", 32'(data), 32'd42);
    // out-of-window access never acknowledged
    seen = 0;
    bus_valid = 1; bus_we = 1; bus_addr = BASE + 32'h20; bus_wdata = 32'd77; bus_wstrb = 4'hF;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus_ready) seen++;
    end
    bus_valid = 0;
    chk("nomatch_ready", 32'(seen), 0);
    // reset during RESP
    bus_valid = 1; bus_we = 1; bus_addr = BASE; bus_wdata = 32'd55; bus_wstrb = 4'hF;
    tick();
    rst = 1;
    #1;
    model_reset();
    chk("rst_ready", 32'(bus_ready), 0);
    chk("rst_data", 32'(data), 0);
    bus_valid = 0;
    tick();
    tick();
    rst = 0;
    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      int k;
      logic [31:0] lo;
      k = $urandom_range(0, 9);
      lo = 32'($urandom_range(0, 3));
      if (k <= 4) wr(BASE + lo, $urandom_range(0, 1) ? 32'($urandom_range(0, 12000)) : $urandom, 4'($urandom));
      else if (k == 5) wr(BASE + 4 + lo, {30'h0, $urandom_range(0, 3) == 0, 1'($urandom)}, 4'($urandom));
      else if (k == 6) wr(BASE + 8 + lo, 32'($urandom_range(0, 3)), 4'($urandom));
      else if (k == 7) rd(BASE + 32'($urandom_range(0, 15)), r);
      else if (k == 8) repeat ($urandom_range(0, 12)) tick();
      else wr($urandom_range(0, 1) ? BASE + 12 : BASE + 32'($urandom_range(16, 63)), $urandom, 4'hF);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/disp_value_reg.md
Name: disp_value_reg

Overview:
- Memory-mapped display register between the rv32 core data bus and the 4-digit 7-segment translator.
- Accepts CPU writes through a valid/ready handshake and saturates the value to the 4-digit decimal range.
- Rate-limits updates to the 16-bit `data` word consumed by the translator, so fast-changing software values stay readable.
- Reports pending and overflow status on readback.

Parameters:
- ADDR_BASE, 32'h1000_0000, word-aligned base of the 16-byte register window.
- HOLD_CYCLES, 32'd1_000_000, minimum clk cycles between successive display commits when hold-off is enabled (must be ≥1).
- MAX_VAL, 16'd9999, saturation ceiling for displayed value.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- bus_valid  in  1  request valid; held until bus_ready
- bus_we  in  1  1 = write, 0 = read
- bus_addr  in  32  byte address
- bus_wdata  in  32  write data
- bus_wstrb  in  4  byte enables
- bus_ready  out  1  one-cycle completion pulse
- bus_rdata  out  32  read data, valid while bus_ready=1, else 0
- data  out  16  binary value to the translator, always ≤ MAX_VAL
- overflow  out  1  sticky saturation flag (mirror of STATUS[1])

Behaviour:
- Register map (offset from ADDR_BASE):
  - 0x0 VALUE (R/W): read returns the committed `data`, zero-extended.
  - 0x4 CTRL (R/W): bit0 HOLD_EN, bit1 FREEZE; other bits read 0.
  - 0x8 STATUS: bit0 PENDING (RO); bit1 OVF (write-1-to-clear).
  - 0xC: reads 0, writes ignored.
- Address decode: match when bus_addr[31:4] == ADDR_BASE[31:4]; bus_addr[1:0] ignored.
  - Non-matching requests are never acknowledged (bus_ready stays 0).
- Handshake FSM, two states:
  - IDLE: on bus_valid and match, perform the access at that clock edge and go to RESP.
  - RESP: bus_ready=1 for exactly one cycle, then return to IDLE. Inputs are not sampled in RESP.
  - Latency: request seen in cycle T → bus_ready in T+1. Back-to-back accesses are therefore spaced at least 2 cycles apart.
- VALUE write:
  - new = {wstrb[1] ? wdata[15:8] : pend_val[15:8], wstrb[0] ? wdata[7:0] : pend_val[7:0]}.
  - If new > MAX_VAL (unsigned compare): pend_val <= MAX_VAL and OVF <= 1. Otherwise pend_val <= new.
  - PENDING <= 1.
- CTRL write: honours wstrb[0] only.
- STATUS write: wstrb[0] and wdata[1] clear OVF. If a saturating VALUE write would set OVF in the same cycle, set wins; this cannot occur under the FSM and is listed for completeness.
- Commit condition, evaluated every cycle: PENDING && !FREEZE && (!HOLD_EN || hold_cnt == 0).
  - On commit: data <= pend_val; PENDING <= 0; hold_cnt <= HOLD_CYCLES-1.
  - Otherwise hold_cnt decrements, saturating at 0.
- Commit and VALUE write in the same cycle:
  - The commit uses the old pend_val.
  - The new write is captured, and PENDING stays 1.
- Multiple writes before a commit: the last one wins; intermediate values are never displayed.
- Hold-off disabled: a VALUE write captured at edge T reaches `data` at edge T+1 (visible 2 cycles after the request).
- FREEZE=1: `data` holds, pend_val and PENDING keep accepting writes, and hold_cnt keeps counting down. Clearing FREEZE commits on the next eligible cycle.
- Width rules:
  - hold_cnt is 32 bits.
  - MAX_VAL values above 9999 are illegal; the translator's thousands digit is 4 bits.
- Reset (async, any time, including mid-transaction): FSM=IDLE, bus_ready=0, bus_rdata=0, data=0, pend_val=0, PENDING=0, OVF=0, CTRL=0, hold_cnt=0.
  - A request interrupted by reset is dropped; the master must reissue it.

Decomposition:
- Shared package holds:
  - register offsets (OFF_VALUE, OFF_CTRL, OFF_STATUS);
  - CTRL/STATUS bit indices;
  - FSM state encoding (ST_IDLE, ST_RESP);
  - the 9999 display limit constant (shared with the translator).
- One natural sub-module: disp_holdoff_timer, containing hold_cnt, the load-on-commit logic and the zero flag.
- Bus decode, FSM and registers stay in the top.

Test Plan:
- Reset then write VALUE=1234 (wstrb=4'hF, HOLD_EN=0) at cycle T → bus_ready=1 at T+1 only; data=1234 by T+2; PENDING returns to 0; overflow=0.
- Write VALUE=16'd12000 → data=9999, overflow=1. Write STATUS=32'h2 → overflow=0, data remains 9999.
- HOLD_CYCLES=10, HOLD_EN=1: write 5, then write 6 two cycles after the commit of 5 → data stays 5 for exactly 10 cycles after that commit, then becomes 6.
- HOLD_EN=1: write 7, 8, 9 within the hold window → data goes directly to 9 and never shows 7 or 8.
- FREEZE=1, write 42 → data unchanged and STATUS read returns 1. Clear FREEZE → data=42 within 2 cycles (HOLD_EN=0).
- Access to ADDR_BASE+0x20 → no bus_ready for 20 cycles. Assert rst during RESP of a VALUE write → bus_ready=0, data=0 immediately.
